// File: rtl/board_input_loader_pkg.sv
// Shared constants and types for the board input loader.
package board_input_loader_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned SHIFT_NUM_W = 8;
  localparam int unsigned SHFT_OP_W   = 3;

  // Button roles
  localparam int unsigned BTN_LOAD_DATA = 0;
  localparam int unsigned BTN_LOAD_CTRL = 1;
  localparam int unsigned BTN_CARRY     = 2;
  localparam int unsigned BTN_CLEAR     = 3;

  // Field positions of the control operands within the switch word
  localparam int unsigned SHIFT_NUM_MSB = 31;
  localparam int unsigned SHIFT_NUM_LSB = 24;
  localparam int unsigned SHFT_OP_MSB   = 23;
  localparam int unsigned SHFT_OP_LSB   = 21;

  typedef struct packed {
    logic [DATA_W-1:0]      data;
    logic [SHIFT_NUM_W-1:0] num;
    logic [SHFT_OP_W-1:0]   op;
  } operand_t;

endpackage

// File: rtl/board_input_loader_debounce_filter.sv
// Single-bit 2-flop synchronizer followed by a stable-count debouncer.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then count consecutive cycles the input disagrees with the level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_input_loader.sv
// Board switch/button front end: debounces buttons, detects presses and
// captures switch words into the shifter operand registers.
module board_input_loader
  import board_input_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_BTN         = 6  // needs at least BTN_CLEAR+1 buttons
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      sw,
  input  logic [NUM_BTN-1:0]     btn,
  output logic [DATA_W-1:0]      shift_data,
  output logic [SHIFT_NUM_W-1:0] shift_num,
  output logic [SHFT_OP_W-1:0]   shft_op,
  output logic                   carry_flag,
  output logic                   data_valid,
  output logic [NUM_BTN-1:0]     btn_level,
  output logic [NUM_BTN-1:0]     btn_press
);

  logic [DATA_W-1:0]  sw_meta;
  logic [DATA_W-1:0]  sw_sync;
  logic [NUM_BTN-1:0] level_dly;
  operand_t           opnd;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (btn_level[i])
    );
  end

  // Switches are only synchronized; they are sampled on a debounced press
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Rising-edge detect, operand load/clear and the valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      level_dly  <= '0;
      btn_press  <= '0;
      opnd       <= '0;
      data_valid <= 1'b0;
    end else begin
      level_dly  <= btn_level;
      btn_press  <= btn_level & ~level_dly;
      data_valid <= 1'b0;
      if (btn_press[BTN_CLEAR]) begin
        // Clear wins over any simultaneous load
        opnd       <= '0;
        data_valid <= 1'b1;
      end else begin
        if (btn_press[BTN_LOAD_DATA]) begin
          opnd.data <= sw_sync;
        end
        if (btn_press[BTN_LOAD_CTRL]) begin
          opnd.num <= sw_sync[SHIFT_NUM_MSB:SHIFT_NUM_LSB];
          opnd.op  <= sw_sync[SHFT_OP_MSB:SHFT_OP_LSB];
        end
        if (btn_press[BTN_LOAD_DATA] || btn_press[BTN_LOAD_CTRL]) begin
          data_valid <= 1'b1;
        end
      end
    end
  end

  assign shift_data = opnd.data;
  assign shift_num  = opnd.num;
  assign shft_op    = opnd.op;
  assign carry_flag = btn_level[BTN_CARRY];

endmodule

// File: tb/tb_board_input_loader.sv
// Self-checking bench for board_input_loader with a short debounce window.
module tb_board_input_loader;

  localparam int unsigned D  = 4;
  localparam int unsigned NB = 6;

  logic          clk;
  logic          rst;
  logic [31:0]   sw;
  logic [NB-1:0] btn;
  logic [31:0]   shift_data;
  logic [7:0]    shift_num;
  logic [2:0]    shft_op;
  logic          carry_flag;
  logic          data_valid;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;

  board_input_loader #(
    .DEBOUNCE_CYCLES (D),
    .NUM_BTN         (NB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .btn        (btn),
    .shift_data (shift_data),
    .shift_num  (shift_num),
    .shft_op    (shft_op),
    .carry_flag (carry_flag),
    .data_valid (data_valid),
    .btn_level  (btn_level),
    .btn_press  (btn_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: raw sample history, debounced level judged from a window
  logic [NB-1:0] bh [0:D];     // bh[0] = raw btn sampled at the previous edge
  logic [31:0]   swh [0:1];    // swh[1] = switches as seen by the loader now
  logic [NB-1:0] m_lvl, m_rose, m_press;
  logic [31:0]   m_data;
  logic [7:0]    m_num;
  logic [2:0]    m_op;
  logic          m_valid;

  task automatic model_edge();
    logic [NB-1:0] old_press;
    logic [NB-1:0] new_lvl;
    logic [31:0]   s;
    if (rst) begin
      for (int k = 0; k <= D; k++) bh[k] = '0;
      swh[0] = '0; swh[1] = '0;
      m_lvl = '0; m_rose = '0; m_press = '0;
      m_data = '0; m_num = '0; m_op = '0; m_valid = 1'b0;
    end else begin
      old_press = m_press;
      m_press   = m_rose;
      // Level flips once the last D synchronized samples all disagree with it
      for (int i = 0; i < NB; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) if (bh[k][i] == m_lvl[i]) all_diff = 1'b0;
        new_lvl[i] = all_diff ? ~m_lvl[i] : m_lvl[i];
      end
      m_rose = new_lvl & ~m_lvl;
      m_lvl  = new_lvl;
      s = swh[1];
      m_valid = old_press[0] | old_press[1] | old_press[3];
      if (old_press[3]) begin
        m_data = '0; m_num = '0; m_op = '0;
      end else begin
        if (old_press[0]) m_data = s;
        if (old_press[1]) begin
          m_num = s[31:24];
          m_op  = s[23:21];
        end
      end
      for (int k = D; k > 0; k--) bh[k] = bh[k-1];
      bh[0]  = btn;
      swh[1] = swh[0];
      swh[0] = sw;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("shift_data", shift_data, m_data);
    check("shift_num", 32'(shift_num), 32'(m_num));
    check("shft_op", 32'(shft_op), 32'(m_op));
    check("carry_flag", 32'(carry_flag), 32'(m_lvl[2]));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("btn_level", 32'(btn_level), 32'(m_lvl));
    check("btn_press", 32'(btn_press), 32'(m_press));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int first_j;
  int strobes;
  int carry_rise;

  initial begin
    rst = 1'b1; btn = '0; sw = 32'hFFFF_FFFF;
    idle(3);
    rst = 1'b0;

    // Idle with all switches high: nothing loads
    idle(20);
    check("idle_data", shift_data, 32'h0);
    check("idle_valid", 32'(data_valid), 32'h0);

    // Load data and hold the button: single strobe, seven edges after the raise
    sw = 32'hDEAD_BEEF;
    idle(4);
    btn[0] = 1'b1;
    first_j = -1; strobes = 0;
    for (int j = 0; j < 50; j++) begin
      step();
      if (data_valid) begin
        strobes++;
        if (first_j < 0) first_j = j;
      end
    end
    check("load_lat", 32'(first_j), 32'd7);
    check("load_once", 32'(strobes), 32'd1);
    check("load_data", shift_data, 32'hDEAD_BEEF);
    btn[0] = 1'b0;
    idle(10);

    // Control load leaves shift_data alone
    sw = 32'h05A0_0000;
    idle(3);
    btn[1] = 1'b1;
    strobes = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (data_valid) strobes++;
    end
    check("ctrl_num", 32'(shift_num), 32'h05);
    check("ctrl_op", 32'(shft_op), 32'h5);
    check("ctrl_data", shift_data, 32'hDEAD_BEEF);
    check("ctrl_once", 32'(strobes), 32'd1);
    btn[1] = 1'b0;
    idle(10);

    // Bounce 1,0,1,0 then stable high
    sw = 32'hCAFE_0123;
    strobes = 0;
    for (int j = 0; j < 4; j++) begin
      btn[0] = (j % 2 == 0);
      step();
      if (data_valid) strobes++;
    end
    check("bounce_quiet", 32'(strobes), 32'd0);
    btn[0] = 1'b1;
    first_j = -1; strobes = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (data_valid) begin
        strobes++;
        if (first_j < 0) first_j = j;
      end
    end
    check("bounce_lat", 32'(first_j), 32'd7);
    check("bounce_once", 32'(strobes), 32'd1);
    check("bounce_data", shift_data, 32'hCAFE_0123);
    btn[0] = 1'b0;
    idle(10);

    // Preload, then clear and load together: clear wins
    sw = 32'h1234_5678;
    idle(3);
    btn[0] = 1'b1;
    idle(12);
    check("preload", shift_data, 32'h1234_5678);
    btn[0] = 1'b0;
    idle(10);
    btn[0] = 1'b1; btn[3] = 1'b1;
    strobes = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (data_valid) strobes++;
    end
    check("clr_data", shift_data, 32'h0);
    check("clr_num", 32'(shift_num), 32'h0);
    check("clr_op", 32'(shft_op), 32'h0);
    check("clr_once", 32'(strobes), 32'd1);
    btn[0] = 1'b0; btn[3] = 1'b0;
    idle(10);

    // Button held through a reset pulse mid-debounce
    sw = 32'hA5E0_0000;
    idle(3);
    btn[1] = 1'b1;
    idle(2);
    rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      check("rst_valid", 32'(data_valid), 32'h0);
    end
    rst = 1'b0;
    first_j = -1; strobes = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (data_valid) begin
        strobes++;
        if (first_j < 0) first_j = j;
      end
    end
    check("rst_lat", 32'(first_j), 32'd7);
    check("rst_once", 32'(strobes), 32'd1);
    check("rst_num", 32'(shift_num), 32'hA5);
    check("rst_op", 32'(shft_op), 32'h7);
    btn[1] = 1'b0;
    idle(10);

    // Carry flag follows the debounced level of btn[2]
    btn[2] = 1'b1;
    carry_rise = -1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (carry_flag && carry_rise < 0) carry_rise = j;
    end
    check("carry_on", 32'(carry_rise), 32'd5);
    btn[2] = 1'b0;
    carry_rise = -1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (!carry_flag && carry_rise < 0) carry_rise = j;
    end
    check("carry_off", 32'(carry_rise), 32'd5);

    // Random slow-moving buttons, random switches, occasional reset
    for (int j = 0; j < 1500; j++) begin
      if ($urandom_range(7) == 0) begin
        int b;
        b = $urandom_range(NB - 1);
        btn[b] = ~btn[b];
      end
      if ($urandom_range(3) == 0) sw = $urandom;
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
